// File: rtl/fft_pipe_ctrl.sv
// fft_pipe_ctrl: control and valid tracking for a fixed-latency pipelined FFT output.
//
// Modes:
//   mode=0 single-shot: hold `start` (a level). LATENCY edges later the unit captures
//          dp_data and keeps out_valid set until `start` drops.
//   mode=1 streaming: issue one token per cycle on `in_valid`. Each token's result is
//          captured LATENCY edges later as a one-cycle out_valid pulse.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   mode                0 single-shot, 1 streaming (registered; a change clears the unit)
//   start               single-shot run request (level)
//   in_valid            streaming token issue
//   flush               synchronous clear (only with FFT_PIPE_CTRL_FLUSH_EN defined)
//   dp_data             datapath result bus, channel 0 in the LSBs
//   out_data/out_valid  captured result and its valid flag (registered)
//   busy                combinational: single-shot !out_valid, streaming inflight!=0
//   inflight            tokens issued but not yet delivered (streaming)
//
// Optional feature macro: FFT_PIPE_CTRL_FLUSH_EN (adds the flush input and its logic).
module fft_pipe_ctrl #(
  parameter  int unsigned LATENCY = 35,
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned N_CH    = 2,
  localparam int unsigned CNT_W   = $clog2(LATENCY + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mode,
  input  logic                   start,
  input  logic                   in_valid,
`ifdef FFT_PIPE_CTRL_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic [N_CH*DATA_W-1:0] dp_data,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic                   out_valid,
  output logic                   busy,
  output logic [CNT_W-1:0]       inflight
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LATENCY-1:0]      vsr_q, vsr_d;
  logic [CNT_W-1:0]        inf_d;
  logic                    ov_d;
  logic [N_CH*DATA_W-1:0]  data_d;
  logic                    mode_q;
  logic                    deliver;

  assign deliver  = vsr_q[LATENCY-1];
  assign busy     = mode ? (inflight != '0) : !out_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      vsr_q     <= '0;
      inflight  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vsr_q     <= vsr_d;
      inflight  <= inf_d;
      out_valid <= ov_d;
      out_data  <= data_d;
      mode_q    <= mode;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vsr_d   = vsr_q;
    inf_d   = inflight;
    ov_d    = out_valid;
    data_d  = out_data;
`ifdef FFT_PIPE_CTRL_FLUSH_EN
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      vsr_d   = '0;
      inf_d   = '0;
      ov_d    = 1'b0;
    end else
`endif
    if (mode != mode_q) begin
      state_d = IDLE;
      cnt_d   = '0;
      vsr_d   = '0;
      inf_d   = '0;
      ov_d    = 1'b0;
    end else if (mode_q) begin
      // Truncating cast keeps the low LATENCY bits, so LATENCY=1 needs no special case.
      vsr_d = LATENCY'({vsr_q, in_valid});
      ov_d  = deliver;
      if (deliver) data_d = dp_data;
      case ({in_valid, deliver})
        2'b10:   inf_d = inflight + ONE_C;
        2'b01:   inf_d = inflight - ONE_C;
        default: inf_d = inflight;
      endcase
    end else if (!start) begin
      state_d = IDLE;
      cnt_d   = '0;
      ov_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = ONE_C;
          state_d = (LATENCY == 1) ? DONE : RUN;
        end
        RUN: begin
          if (cnt_q == LAT_C) begin
            data_d  = dp_data;
            ov_d    = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
        DONE: begin
          cnt_d = LAT_C;
          // Entered directly from IDLE when LATENCY=1: capture on the first DONE edge.
          if (!out_valid) begin
            data_d = dp_data;
            ov_d   = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule
